// File: rtl/arb_pkg.sv
// Shared arbiter definitions: request-count limits, lowest-set-bit helper and
// parameter-range check macros used by every arbiter in the family.
`ifndef ARB_PKG_SV
`define ARB_PKG_SV

// Elaboration-time range check on an integer parameter; expands to a generate block.
`define ARB_CHECK_RANGE(P, LO, HI) \
  if (((P) < (LO)) || ((P) > (HI))) begin : g_bad_range \
    $error("arbiter parameter out of range"); \
  end

package arb_pkg;

  localparam int ARB_MAX_REQ = 64;

  typedef logic [ARB_MAX_REQ-1:0] arb_vec_t;

  // Two's-complement trick: v - 1 flips the lowest set bit and everything below it.
  function automatic arb_vec_t onehot_lsb(input arb_vec_t v);
    return v & ~(v - arb_vec_t'(1));
  endfunction

endpackage

`endif

// File: rtl/fixed_pri_sel.sv
// Combinational fixed-priority select: one-hot of the lowest-index set request bit.
module fixed_pri_sel
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] sel_o
);

  assign sel_o = req_i & ~(req_i - NUM_REQ'(1));

endmodule

// File: rtl/fixed_pri_arbiter.sv
// Fixed-priority arbiter (req[0] highest) with a registered one-hot grant.
module fixed_pri_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);

  `ARB_CHECK_RANGE(NUM_REQ, 2, ARB_MAX_REQ)

  logic [NUM_REQ-1:0] gnt_d;
  logic [NUM_REQ-1:0] gnt_q;

  fixed_pri_sel #(.NUM_REQ(NUM_REQ)) u_sel (
    .req_i (req),
    .sel_o (gnt_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) gnt_q <= '0;
    else      gnt_q <= gnt_d;
  end

  assign gnt = gnt_q;

`ifndef SYNTHESIS
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt_q));
  // A grant seen at this edge was computed from req sampled at the previous edge.
  a_gnt_had_req: assert property (@(posedge clk) disable iff (!rst)
                                  (gnt_q & ~$past(req)) == '0);
  a_req_known:   assert property (@(posedge clk) disable iff (!rst) !$isunknown(req));
`endif

endmodule

// File: tb/tb_fixed_pri_arbiter.sv
// Randomised and directed check of fixed_pri_arbiter at NUM_REQ = 4 and 8.
module tb_fixed_pri_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req4 = '0;
  logic [7:0] req8 = '0;
  logic [3:0] gnt4;
  logic [7:0] gnt8;

  int n_cmp  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  fixed_pri_arbiter #(.NUM_REQ(4)) dut4 (.clk(clk), .rst(rst), .req(req4), .gnt(gnt4));
  fixed_pri_arbiter #(.NUM_REQ(8)) dut8 (.clk(clk), .rst(rst), .req(req8), .gnt(gnt8));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: scan upward for the first requester asking.
  function automatic logic [63:0] winner(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++)
      if (v[i]) return 64'(1) << i;
    return 64'(0);
  endfunction

  // Drive new requests between edges, then check one edge later.
  task automatic step(input string tag, input logic [3:0] r4, input logic [7:0] r8);
    @(negedge clk);
    req4 = r4;
    req8 = r8;
    @(posedge clk);
    #1;
    chk({tag, "/4"}, 64'(gnt4), winner(64'(r4), 4));
    chk({tag, "/8"}, 64'(gnt8), winner(64'(r8), 8));
  endtask

  task automatic step4(input string tag, input logic [3:0] r4, input logic [3:0] exp4);
    @(negedge clk);
    req4 = r4;
    @(posedge clk);
    #1;
    chk(tag, 64'(gnt4), 64'(exp4));
  endtask

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    #1000;
    chk("rst_hold4", 64'(gnt4), 64'(0));
    chk("rst_hold8", 64'(gnt8), 64'(0));
    req4 = 4'b1111;
    req8 = 8'hff;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req4", 64'(gnt4), 64'(0));
    chk("rst_req8", 64'(gnt8), 64'(0));

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_no_edge", 64'(gnt4), 64'(0));
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      chk("all_ones4", 64'(gnt4), 64'(4'b0001));
      chk("all_ones8", 64'(gnt8), 64'(8'h01));
    end

    step4("pri_1010", 4'b1010, 4'b0010);
    step4("pri_1000", 4'b1000, 4'b1000);
    step4("pri_1100", 4'b1100, 4'b0100);
    step4("pri_0000", 4'b0000, 4'b0000);
    step4("pre_1000", 4'b1000, 4'b1000);
    step4("pre_1001", 4'b1001, 4'b0001);
    step4("drop_1000", 4'b1000, 4'b1000);

    // Grant 0001 established, then reset pulsed well away from any edge.
    step4("ar_setup", 4'b1111, 4'b0001);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("ar_async_clr", 64'(gnt4), 64'(0));
    #1 rst = 1'b1;
    #1;
    chk("ar_still_clr", 64'(gnt4), 64'(0));
    @(posedge clk);
    #1;
    chk("ar_resume", 64'(gnt4), 64'(4'b0001));

    for (int v = 0; v < 256; v++) begin
      logic [7:0] vb;
      vb = 8'(v);
      step("sweep", vb[3:0], vb);
    end

    for (int k = 0; k < 300; k++) begin
      logic [7:0] r8;
      logic [3:0] r4;
      r8 = 8'($urandom);
      r4 = 4'($urandom);
      // Bias towards sparse vectors so high-index winners show up often.
      if ($urandom_range(0, 1) == 1) r8 = r8 & 8'($urandom);
      if ($urandom_range(0, 1) == 1) r4 = r4 & 4'($urandom);
      step("rand", r4, r8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_miss);
    $finish;
  end

endmodule
